// File: rtl/core_exec_pkg.sv
// Shared execution-stage types: ALU request/response records, opcode width and
// requester identities used by the ALU arbiter and its neighbours.
package core_exec_pkg;

    localparam int DATA_W   = 32;
    localparam int TAG_W    = 4;
    localparam int ALU_OP_W = 5;

    // Requester identities; the ALU is shared by exactly these two units.
    typedef enum logic [0:0] {
        REQ_INT = 1'b0,   // integer pipe
        REQ_BRU = 1'b1    // branch / address-generation unit
    } req_id_e;

    typedef struct packed {
        logic [DATA_W-1:0]   a;
        logic [DATA_W-1:0]   b;
        logic [ALU_OP_W-1:0] op;
        logic                invert;
        logic [TAG_W-1:0]    tag;
    } alu_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [DATA_W:0]   adder;
        logic              comp;
        logic [TAG_W-1:0]  tag;
    } alu_rsp_t;

    // Round-robin successor: the requester after the one just served.
    function automatic req_id_e next_req(input req_id_e id);
        return (id == REQ_BRU) ? REQ_INT : REQ_BRU;
    endfunction

endpackage

// File: rtl/core_alu_arbiter_rr_arbiter.sv
// Generic round-robin arbiter: scans the request vector starting at the pointer
// position and returns a one-hot grant for the first valid requester found.
module rr_arbiter #(
    parameter  int N     = 2,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    // Priority scan rotated by the pointer; the pointer position has highest priority.
    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PTR_W'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_alu_arbiter.sv
// Shares the execution-stage ALU between the integer pipe and the branch unit.
// A round-robin arbiter picks one requester per cycle, the winner's operands
// drive the external combinational ALU, and the ALU outputs are captured in a
// single-entry response buffer that the owning requester drains.
module core_alu_arbiter
    import core_exec_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int NUM_REQ    = 2,        // fixed at two requesters in this revision
    parameter int TAG_WIDTH  = TAG_W
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    // requester side
    input  logic [NUM_REQ-1:0]              req_valid_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b_i,
    input  logic [NUM_REQ*ALU_OP_W-1:0]     req_op_i,
    input  logic [NUM_REQ-1:0]              req_invert_i,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]    req_tag_i,
    // ALU side
    output logic [DATA_WIDTH-1:0]           alu_operand_a_o,
    output logic [DATA_WIDTH-1:0]           alu_operand_b_o,
    output logic [ALU_OP_W-1:0]             alu_op_o,
    output logic                            alu_invert_o,
    input  logic [DATA_WIDTH-1:0]           alu_result_i,
    input  logic [DATA_WIDTH:0]             alu_adder_i,
    input  logic                            alu_comp_i,
    // response side
    output logic [NUM_REQ-1:0]              rsp_valid_o,
    input  logic [NUM_REQ-1:0]              rsp_ready_i,
    output logic [DATA_WIDTH-1:0]           rsp_result_o,
    output logic [DATA_WIDTH:0]             rsp_adder_o,
    output logic                            rsp_comp_o,
    output logic [TAG_WIDTH-1:0]            rsp_tag_o
);

    req_id_e              rr_ptr;
    req_id_e              gnt_id;
    logic [NUM_REQ-1:0]   arb_req;
    logic [NUM_REQ-1:0]   grant;
    logic                 any_grant;
    logic                 drain;
    logic                 buf_free;

    // rsp_valid_o is one-hot on the owner, so masking with rsp_ready_i ignores
    // the non-owner's ready.
    assign drain    = |(rsp_valid_o & rsp_ready_i);
    assign buf_free = ~|rsp_valid_o | drain;

    // Nothing is offered to the arbiter while the buffer is blocked or in reset.
    assign arb_req = (buf_free && !rst_i) ? req_valid_i : '0;

    rr_arbiter #(
        .N     (NUM_REQ)
    ) u_rr_arbiter (
        .req   (arb_req),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    assign any_grant   = |grant;
    assign req_ready_o = grant;

    // With no grant the encoded id falls back to the integer pipe, which is
    // what the ALU sees as don't-care operands.
    assign gnt_id = grant[1] ? REQ_BRU : REQ_INT;

    assign alu_operand_a_o = req_a_i[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
    assign alu_operand_b_o = req_b_i[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
    assign alu_op_o        = req_op_i[int'(gnt_id)*ALU_OP_W +: ALU_OP_W];
    assign alu_invert_o    = req_invert_i[gnt_id];

    // Response buffer and round-robin pointer: load on grant, clear on drain-only, else hold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the buffer payload is reset too, so outputs read as zero (not X) after reset.
            rsp_valid_o  <= '0;
            rsp_result_o <= '0;
            rsp_adder_o  <= '0;
            rsp_comp_o   <= 1'b0;
            rsp_tag_o    <= '0;
            rr_ptr       <= REQ_INT;
        end else if (any_grant) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            rsp_valid_o  <= grant;
            rsp_result_o <= alu_result_i;
            rsp_adder_o  <= alu_adder_i;
            rsp_comp_o   <= alu_comp_i;
            rsp_tag_o    <= req_tag_i[int'(gnt_id)*TAG_WIDTH +: TAG_WIDTH];
            rr_ptr       <= next_req(gnt_id);
        end else if (drain) begin
            rsp_valid_o  <= '0;
        end
    end

endmodule

// File: tb/tb_core_alu_arbiter.sv
// Self-checking bench for core_alu_arbiter. A small behavioural ALU stands in
// for the real one; directed stimulus pushes hand-computed responses into a
// scoreboard queue and a monitor compares them on every response handshake.
module tb_core_alu_arbiter;
    import core_exec_pkg::*;

    localparam int DW = 32;
    localparam int NR = 2;
    localparam int TW = 4;

    localparam logic [ALU_OP_W-1:0] OP_ADD = 5'd0;
    localparam logic [ALU_OP_W-1:0] OP_SUB = 5'd1;
    localparam logic [ALU_OP_W-1:0] OP_XOR = 5'd2;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic [NR-1:0]          req_valid_i;
    logic [NR-1:0]          req_ready_o;
    logic [NR*DW-1:0]       req_a_i;
    logic [NR*DW-1:0]       req_b_i;
    logic [NR*ALU_OP_W-1:0] req_op_i;
    logic [NR-1:0]          req_invert_i;
    logic [NR*TW-1:0]       req_tag_i;
    logic [DW-1:0]          alu_operand_a_o;
    logic [DW-1:0]          alu_operand_b_o;
    logic [ALU_OP_W-1:0]    alu_op_o;
    logic                   alu_invert_o;
    logic [DW-1:0]          alu_result_i;
    logic [DW:0]            alu_adder_i;
    logic                   alu_comp_i;
    logic [NR-1:0]          rsp_valid_o;
    logic [NR-1:0]          rsp_ready_i;
    logic [DW-1:0]          rsp_result_o;
    logic [DW:0]            rsp_adder_o;
    logic                   rsp_comp_o;
    logic [TW-1:0]          rsp_tag_o;

    core_alu_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .TAG_WIDTH  (TW)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_a_i         (req_a_i),
        .req_b_i         (req_b_i),
        .req_op_i        (req_op_i),
        .req_invert_i    (req_invert_i),
        .req_tag_i       (req_tag_i),
        .alu_operand_a_o (alu_operand_a_o),
        .alu_operand_b_o (alu_operand_b_o),
        .alu_op_o        (alu_op_o),
        .alu_invert_o    (alu_invert_o),
        .alu_result_i    (alu_result_i),
        .alu_adder_i     (alu_adder_i),
        .alu_comp_i      (alu_comp_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_result_o    (rsp_result_o),
        .rsp_adder_o     (rsp_adder_o),
        .rsp_comp_o      (rsp_comp_o),
        .rsp_tag_o       (rsp_tag_o)
    );

    always #5 clk_i = ~clk_i;

    // Stand-in ALU: invert complements B; adder is always A+B_eff; comp is unsigned A<B_eff.
    always_comb begin
        logic [DW-1:0] b_eff;
        b_eff       = alu_invert_o ? ~alu_operand_b_o : alu_operand_b_o;
        alu_adder_i = {1'b0, alu_operand_a_o} + {1'b0, b_eff};
        alu_comp_i  = alu_operand_a_o < b_eff;
        case (alu_op_o)
            OP_ADD:  alu_result_i = alu_adder_i[DW-1:0];
            OP_SUB:  alu_result_i = alu_operand_a_o - b_eff;
            default: alu_result_i = alu_operand_a_o ^ b_eff;
        endcase
    end

    typedef struct {
        logic [NR-1:0] owner;
        alu_rsp_t      rsp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [NR-1:0] owner, input logic [DW-1:0] result,
                            input logic [DW:0] adder, input logic comp, input logic [TW-1:0] tag);
        exp_t e;
        e.owner      = owner;
        e.rsp.result = result;
        e.rsp.adder  = adder;
        e.rsp.comp   = comp;
        e.rsp.tag    = tag;
        sb_q.push_back(e);
    endtask

    task automatic set_req(input req_id_e id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [ALU_OP_W-1:0] op, input logic inv, input logic [TW-1:0] tag);
        if (id == REQ_INT) begin
            req_a_i[DW-1:0]         = a;
            req_b_i[DW-1:0]         = b;
            req_op_i[ALU_OP_W-1:0]  = op;
            req_invert_i[0]         = inv;
            req_tag_i[TW-1:0]       = tag;
        end else begin
            req_a_i[2*DW-1:DW]              = a;
            req_b_i[2*DW-1:DW]              = b;
            req_op_i[2*ALU_OP_W-1:ALU_OP_W] = op;
            req_invert_i[1]                 = inv;
            req_tag_i[2*TW-1:TW]            = tag;
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: every response handshake outside reset consumes one scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_i && |(rsp_valid_o & rsp_ready_i)) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_rsp", 64'(rsp_valid_o), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_owner",  64'(rsp_valid_o),  64'(e.owner));
                    check("rsp_result", 64'(rsp_result_o), 64'(e.rsp.result));
                    check("rsp_adder",  64'(rsp_adder_o),  64'(e.rsp.adder));
                    check("rsp_comp",   64'(rsp_comp_o),   64'(e.rsp.comp));
                    check("rsp_tag",    64'(rsp_tag_o),    64'(e.rsp.tag));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i        = 1'b1;
        req_valid_i  = 2'b11;
        rsp_ready_i  = 2'b00;
        req_a_i      = '0;
        req_b_i      = '0;
        req_op_i     = '0;
        req_invert_i = '0;
        req_tag_i    = '0;

        // Reset held three cycles with both requesters valid.
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_ready",     64'(req_ready_o),  64'd0);
        check("reset_rsp_valid", 64'(rsp_valid_o),  64'd0);
        check("reset_result",    64'(rsp_result_o), 64'd0);
        check("reset_adder",     64'(rsp_adder_o),  64'd0);
        check("reset_tag",       64'(rsp_tag_o),    64'd0);

        // Single request from the integer pipe: 5+3, tag 2.
        step();
        rst_i       = 1'b0;
        req_valid_i = 2'b01;
        rsp_ready_i = 2'b11;
        set_req(REQ_INT, 32'd5, 32'd3, OP_ADD, 1'b0, 4'd2);
        @(negedge clk_i);
        check("single_ready0", 64'(req_ready_o), 64'b01);
        push_exp(2'b01, 32'd8, 33'd8, 1'b0, 4'd2);

        // Single request from the branch unit moves the pointer back to req 0.
        step();
        req_valid_i = 2'b10;
        set_req(REQ_BRU, 32'd10, 32'd4, OP_SUB, 1'b0, 4'd7);
        @(negedge clk_i);
        check("single_rsp_valid", 64'(rsp_valid_o), 64'b01);
        check("single_ready1",    64'(req_ready_o), 64'b10);
        push_exp(2'b10, 32'd6, 33'd14, 1'b0, 4'd7);

        // Contention: both valid for four cycles, grants alternate 0,1,0,1.
        step();
        req_valid_i = 2'b11;
        set_req(REQ_INT, 32'd1,   32'd2, OP_ADD, 1'b0, 4'd1);
        set_req(REQ_BRU, 32'd100, 32'd1, OP_XOR, 1'b1, 4'd9);
        @(negedge clk_i);
        check("cont0_ready", 64'(req_ready_o), 64'b01);
        push_exp(2'b01, 32'd3, 33'd3, 1'b1, 4'd1);

        step();
        set_req(REQ_INT, 32'hFFFF_FFFF, 32'd1, OP_ADD, 1'b0, 4'd3);
        @(negedge clk_i);
        check("cont1_ready",  64'(req_ready_o),  64'b10);
        check("cont1_rsp",    64'(rsp_valid_o),  64'b01);
        check("cont1_invert", 64'(alu_invert_o), 64'd1);
        push_exp(2'b10, 32'hFFFF_FF9A, 33'h1_0000_0062, 1'b1, 4'd9);

        step();
        set_req(REQ_BRU, 32'd7, 32'd7, OP_SUB, 1'b0, 4'd15);
        @(negedge clk_i);
        check("cont2_ready", 64'(req_ready_o), 64'b01);
        check("cont2_rsp",   64'(rsp_valid_o), 64'b10);
        push_exp(2'b01, 32'd0, 33'h1_0000_0000, 1'b0, 4'd3);

        step();
        @(negedge clk_i);
        check("cont3_ready", 64'(req_ready_o), 64'b10);
        check("cont3_rsp",   64'(rsp_valid_o), 64'b01);
        push_exp(2'b10, 32'd0, 33'd14, 1'b0, 4'd15);

        // Back-pressure: req1 granted, then its consumer stalls for three cycles.
        step();
        req_valid_i = 2'b10;
        set_req(REQ_BRU, 32'd20, 32'd22, OP_ADD, 1'b0, 4'd5);
        @(negedge clk_i);
        check("bp_grant1",     64'(req_ready_o), 64'b10);
        check("bp_prev_rsp",   64'(rsp_valid_o), 64'b10);
        push_exp(2'b10, 32'd42, 33'd42, 1'b1, 4'd5);

        step();
        req_valid_i = 2'b01;
        rsp_ready_i = 2'b01;
        set_req(REQ_INT, 32'd9, 32'd9, OP_XOR, 1'b0, 4'd6);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check("bp_stall_ready",  64'(req_ready_o),  64'd0);
            check("bp_stall_valid",  64'(rsp_valid_o),  64'b10);
            check("bp_stall_result", 64'(rsp_result_o), 64'd42);
            check("bp_stall_tag",    64'(rsp_tag_o),    64'd5);
            step();
        end
        rsp_ready_i = 2'b10;
        @(negedge clk_i);
        check("bp_release_grant0", 64'(req_ready_o), 64'b01);
        push_exp(2'b01, 32'd0, 33'd18, 1'b0, 4'd6);

        // Non-owner ready: buffer owned by req0, only req1 is ready.
        step();
        req_valid_i = 2'b10;
        set_req(REQ_BRU, 32'd3, 32'd1, OP_SUB, 1'b0, 4'd4);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            check("nonowner_valid", 64'(rsp_valid_o),  64'b01);
            check("nonowner_ready", 64'(req_ready_o),  64'd0);
            check("nonowner_tag",   64'(rsp_tag_o),    64'd6);
            step();
        end
        rsp_ready_i = 2'b01;
        @(negedge clk_i);
        check("nonowner_release", 64'(req_ready_o), 64'b10);
        push_exp(2'b10, 32'd2, 33'd4, 1'b0, 4'd4);

        // Reset mid-operation with a full buffer owned by req1.
        step();
        req_valid_i = 2'b00;
        rsp_ready_i = 2'b00;
        @(negedge clk_i);
        check("mid_full_valid",  64'(rsp_valid_o),  64'b10);
        check("mid_full_result", 64'(rsp_result_o), 64'd2);

        step();
        rst_i       = 1'b1;
        req_valid_i = 2'b11;
        rsp_ready_i = 2'b11;
        @(negedge clk_i);
        check("mid_rst_ready", 64'(req_ready_o), 64'd0);
        sb_q.delete();

        step();
        rst_i = 1'b0;
        set_req(REQ_INT, 32'd2, 32'd2, OP_ADD, 1'b0, 4'd8);
        set_req(REQ_BRU, 32'd0, 32'd1, OP_SUB, 1'b0, 4'd1);
        @(negedge clk_i);
        check("post_rst_valid",  64'(rsp_valid_o), 64'd0);
        check("post_rst_grant0", 64'(req_ready_o), 64'b01);
        push_exp(2'b01, 32'd4, 33'd4, 1'b0, 4'd8);

        step();
        req_valid_i = 2'b10;
        @(negedge clk_i);
        check("post_rst_grant1", 64'(req_ready_o), 64'b10);
        check("post_rst_rsp0",   64'(rsp_valid_o), 64'b01);
        push_exp(2'b10, 32'hFFFF_FFFF, 33'd1, 1'b1, 4'd1);

        step();
        req_valid_i = 2'b00;
        @(negedge clk_i);
        check("drain_ready", 64'(req_ready_o), 64'd0);
        check("drain_rsp1",  64'(rsp_valid_o), 64'b10);

        step();
        @(negedge clk_i);
        check("idle_valid", 64'(rsp_valid_o), 64'd0);
        check("sb_empty",   64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
